id_stage_pipe: RTL and testbench

- Parametrised next-generation decode stage: instruction decode, control generation, register file, hazard-aware ID/EX pipeline register.
- Sits between the fetch stage and EX.
- Adds over the previous decode stage:
  - valid/ready handshake on both sides;
  - flush;
  - automatic load-use bubble insertion;
  - write-to-read bypass;
  - configurable XLEN and register count (RV32I/RV32E);
  - full U-type (LUI) support;
  - an illegal-instruction flag.

---
 rtl/id_stage_pipe.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with register file, load-use
// bubble insertion, write-to-read bypass and a handshaked ID/EX register.
module id_stage_pipe #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_instr,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   input  logic            ex_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_rs1_data,
   output logic [XLEN-1:0] id_rs2_data,
   output logic [XLEN-1:0] id_imm,
   output logic [4:0]      id_rd,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [2:0]      id_funct3,
   output logic [6:0]      id_funct7,
   output logic [7:0]      id_ctl,
   output logic            id_jal,
   output logic            id_jalr,
   output logic            id_auipc,
   output logic            id_lui,
   output logic            id_illegal
);

   localparam int IDX_W = $clog2(NUM_REGS);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // Sign-extend a 32-bit immediate to the datapath width.
   function automatic logic [XLEN-1:0] sext_xlen(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // True when a register index does not exist in this configuration.
   function automatic logic idx_oob(input logic [4:0] idx);
      return (int'(idx) >= NUM_REGS);
   endfunction

   // Fields of the presented instruction
   logic [6:0] f_op;
   logic [4:0] f_rd, f_rs1, f_rs2;
   assign f_op  = if_instr[6:0];
   assign f_rd  = if_instr[11:7];
   assign f_rs1 = if_instr[19:15];
   assign f_rs2 = if_instr[24:20];

   // Decode results
   logic [7:0]  dec_ctl;
   logic [31:0] dec_imm32;
   logic        dec_use_rs1, dec_use_rs2, dec_use_rd, dec_known;
   logic        dec_jal, dec_jalr, dec_auipc, dec_lui;
   logic        dec_illegal;

   // Register file and read ports
   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic [XLEN-1:0] rs1_rdata, rs2_rdata;
   logic            wb_hit;

   // ID/EX pipeline register
   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [6:0]      funct7_q, funct7_d;
   logic [7:0]      ctl_q, ctl_d;
   logic [4:0]      flags_q, flags_d;   // {illegal, lui, auipc, jalr, jal}

   logic adv, haz;

   // Opcode decode: control word, immediate format and which register fields are used
   always_comb begin
      dec_ctl     = 8'h00;
      dec_imm32   = 32'h0;
      dec_use_rs1 = 1'b0;
      dec_use_rs2 = 1'b0;
      dec_use_rd  = 1'b0;
      dec_known   = 1'b1;
      dec_jal     = 1'b0;
      dec_jalr    = 1'b0;
      dec_auipc   = 1'b0;
      dec_lui     = 1'b0;
      case (f_op)
         OP_R: begin
            dec_ctl     = 8'h22;
            dec_use_rs1 = 1'b1;
            dec_use_rs2 = 1'b1;
            dec_use_rd  = 1'b1;
         end
         OP_IMM: begin
            dec_ctl     = 8'hA3;
            dec_imm32   = {{20{if_instr[31]}}, if_instr[31:20]};
            dec_use_rs1 = 1'b1;
            dec_use_rd  = 1'b1;
         end
         OP_LOAD: begin
            dec_ctl     = 8'hF0;
            dec_imm32   = {{20{if_instr[31]}}, if_instr[31:20]};
            dec_use_rs1 = 1'b1;
            dec_use_rd  = 1'b1;
         end
         OP_STORE: begin
            dec_ctl     = 8'h88;
            dec_imm32   = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            dec_use_rs1 = 1'b1;
            dec_use_rs2 = 1'b1;
         end
         OP_BRANCH: begin
            dec_ctl     = 8'h05;
            dec_imm32   = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                           if_instr[30:25], if_instr[11:8], 1'b0};
            dec_use_rs1 = 1'b1;
            dec_use_rs2 = 1'b1;
         end
         OP_JAL: begin
            dec_ctl     = 8'h24;
            dec_imm32   = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                           if_instr[20], if_instr[30:21], 1'b0};
            dec_use_rd  = 1'b1;
            dec_jal     = 1'b1;
         end
         OP_JALR: begin
            dec_ctl     = 8'hA7;
            dec_imm32   = {{20{if_instr[31]}}, if_instr[31:20]};
            dec_use_rs1 = 1'b1;
            dec_use_rd  = 1'b1;
            dec_jalr    = 1'b1;
         end
         OP_AUIPC: begin
            dec_ctl     = 8'hA0;
            dec_imm32   = {if_instr[31:12], 12'b0};
            dec_use_rd  = 1'b1;
            dec_auipc   = 1'b1;
         end
         OP_LUI: begin
            dec_ctl     = 8'hA0;
            dec_imm32   = {if_instr[31:12], 12'b0};
            dec_use_rd  = 1'b1;
            dec_lui     = 1'b1;
         end
         default: dec_known = 1'b0;
      endcase
   end

   // Unknown opcodes and register indices beyond the file are both illegal
   assign dec_illegal = !dec_known
                      || (dec_use_rd  && idx_oob(f_rd))
                      || (dec_use_rs1 && idx_oob(f_rs1))
                      || (dec_use_rs2 && idx_oob(f_rs2));

   // A writeback only lands for a real, existing, nonzero register
   assign wb_hit = wb_we && (wb_rd != 5'd0) && !idx_oob(wb_rd);

   // Combinational register reads with same-cycle writeback bypass
   always_comb begin
      rs1_rdata = '0;
      rs2_rdata = '0;
      if (f_rs1 != 5'd0 && !idx_oob(f_rs1)) begin
         if (wb_hit && wb_rd == f_rs1) rs1_rdata = wb_data;
         else                          rs1_rdata = regs_q[f_rs1[IDX_W-1:0]];
      end
      if (f_rs2 != 5'd0 && !idx_oob(f_rs2)) begin
         if (wb_hit && wb_rd == f_rs2) rs2_rdata = wb_data;
         else                          rs2_rdata = regs_q[f_rs2[IDX_W-1:0]];
      end
   end

   // Handshake: a load in ID/EX whose result the incoming instruction reads forces a bubble
   assign adv      = !valid_q || ex_ready;
   assign haz      = valid_q && ctl_q[4] && (rd_q != 5'd0) && if_valid
                   && ((dec_use_rs1 && f_rs1 == rd_q) || (dec_use_rs2 && f_rs2 == rd_q));
   assign if_ready = adv && !haz && !flush && !reset;

   // Next state of the ID/EX register: flush, bubble, capture or hold
   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rd_d       = rd_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      funct3_d   = funct3_q;
      funct7_d   = funct7_q;
      ctl_d      = ctl_q;
      flags_d    = flags_q;
      if (flush) begin
         valid_d = 1'b0;
         ctl_d   = 8'h00;
         flags_d = 5'b0;
      end else if (adv && haz) begin
         valid_d = 1'b0;
         ctl_d   = 8'h00;
      end else if (adv && if_valid) begin
         valid_d    = 1'b1;
         pc_d       = if_pc;
         rs1_data_d = rs1_rdata;
         rs2_data_d = rs2_rdata;
         rd_d       = f_rd;
         rs1_d      = f_rs1;
         rs2_d      = f_rs2;
         funct3_d   = if_instr[14:12];
         funct7_d   = if_instr[31:25];
         if (dec_illegal) begin
            ctl_d   = 8'h00;
            imm_d   = '0;
            flags_d = 5'b10000;
         end else begin
            ctl_d   = dec_ctl;
            imm_d   = sext_xlen(dec_imm32);
            flags_d = {1'b0, dec_lui, dec_auipc, dec_jalr, dec_jal};
         end
      end else if (adv) begin
         valid_d = 1'b0;
         ctl_d   = 8'h00;
      end else begin
         // Held by EX: keep operands current with writebacks to the held sources
         if (wb_hit && wb_rd == rs1_q) rs1_data_d = wb_data;
         if (wb_hit && wb_rd == rs2_q) rs2_data_d = wb_data;
      end
   end

   // ID/EX register update
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         funct3_q   <= '0;
         funct7_q   <= '0;
         ctl_q      <= '0;
         flags_q    <= '0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rd_q       <= rd_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         funct3_q   <= funct3_d;
         funct7_q   <= funct7_d;
         ctl_q      <= ctl_d;
         flags_q    <= flags_d;
      end
   end

   // Register file: cleared on reset, written by the writeback port
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wb_hit) begin
         regs_q[wb_rd[IDX_W-1:0]] <= wb_data;
      end
   end

   assign id_valid    = valid_q;
   assign id_pc       = pc_q;
   assign id_rs1_data = rs1_data_q;
   assign id_rs2_data = rs2_data_q;
   assign id_imm      = imm_q;
   assign id_rd       = rd_q;
   assign id_rs1      = rs1_q;
   assign id_rs2      = rs2_q;
   assign id_funct3   = funct3_q;
   assign id_funct7   = funct7_q;
   assign id_ctl      = ctl_q;
   assign id_jal      = flags_q[0];
   assign id_jalr     = flags_q[1];
   assign id_auipc    = flags_q[2];
   assign id_lui      = flags_q[3];
   assign id_illegal  = flags_q[4];

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed scenarios plus random traffic for id_stage_pipe,
// checked against a behavioural model of the decode stage.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        reset, if_valid, wb_we, flush, ex_ready;
   logic [31:0] if_pc, if_instr, wb_data;
   logic [4:0]  wb_rd;

   logic        if_ready, id_valid, id_jal, id_jalr, id_auipc, id_lui, id_illegal;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rd, id_rs1, id_rs2;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;
   logic [7:0]  id_ctl;

   logic        e_if_ready, e_valid, e_jal, e_jalr, e_auipc, e_lui, e_illegal;
   logic [31:0] e_pc, e_rs1_data, e_rs2_data, e_imm;
   logic [4:0]  e_rd, e_rs1, e_rs2;
   logic [2:0]  e_funct3;
   logic [6:0]  e_funct7;
   logic [7:0]  e_ctl;

   always #5 clk = ~clk;

   id_stage_pipe #(.XLEN(32), .NUM_REGS(32)) u_dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_instr(if_instr), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_funct3(id_funct3), .id_funct7(id_funct7), .id_ctl(id_ctl),
      .id_jal(id_jal), .id_jalr(id_jalr), .id_auipc(id_auipc), .id_lui(id_lui),
      .id_illegal(id_illegal));

   id_stage_pipe #(.XLEN(32), .NUM_REGS(16)) u_dut_e (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(e_if_ready),
      .if_pc(if_pc), .if_instr(if_instr), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready), .id_valid(e_valid),
      .id_pc(e_pc), .id_rs1_data(e_rs1_data), .id_rs2_data(e_rs2_data),
      .id_imm(e_imm), .id_rd(e_rd), .id_rs1(e_rs1), .id_rs2(e_rs2),
      .id_funct3(e_funct3), .id_funct7(e_funct7), .id_ctl(e_ctl),
      .id_jal(e_jal), .id_jalr(e_jalr), .id_auipc(e_auipc), .id_lui(e_lui),
      .id_illegal(e_illegal));

   int n_vec = 0;
   int n_mis = 0;
   logic rdy_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0]  ctl;
      logic [31:0] imm;
      logic        u1, u2;
      logic [4:0]  flags;   // {illegal, lui, auipc, jalr, jal}
   } dec_t;

   function automatic dec_t ref_decode(input logic [31:0] w);
      dec_t d;
      logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm;
      i_imm = {{20{w[31]}}, w[31:20]};
      s_imm = {{20{w[31]}}, w[31:25], w[11:7]};
      b_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      j_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      u_imm = {w[31:12], 12'b0};
      d = '0;
      case (w[6:0])
         7'h33: begin d.ctl = 8'h22; d.u1 = 1; d.u2 = 1; end
         7'h13: begin d.ctl = 8'hA3; d.imm = i_imm; d.u1 = 1; end
         7'h03: begin d.ctl = 8'hF0; d.imm = i_imm; d.u1 = 1; end
         7'h23: begin d.ctl = 8'h88; d.imm = s_imm; d.u1 = 1; d.u2 = 1; end
         7'h63: begin d.ctl = 8'h05; d.imm = b_imm; d.u1 = 1; d.u2 = 1; end
         7'h6F: begin d.ctl = 8'h24; d.imm = j_imm; d.flags = 5'b00001; end
         7'h67: begin d.ctl = 8'hA7; d.imm = i_imm; d.u1 = 1; d.flags = 5'b00010; end
         7'h17: begin d.ctl = 8'hA0; d.imm = u_imm; d.flags = 5'b00100; end
         7'h37: begin d.ctl = 8'hA0; d.imm = u_imm; d.flags = 5'b01000; end
         default: d.flags = 5'b10000;
      endcase
      return d;
   endfunction

   logic        m_valid = 1'b0;
   logic [31:0] m_pc = 0, m_rs1d = 0, m_rs2d = 0, m_imm = 0;
   logic [4:0]  m_rd = 0, m_rs1 = 0, m_rs2 = 0, m_flags = 0;
   logic [2:0]  m_f3 = 0;
   logic [6:0]  m_f7 = 0;
   logic [7:0]  m_ctl = 0;
   logic [31:0] mrf [32];

   function automatic logic model_haz();
      dec_t d;
      d = ref_decode(if_instr);
      return m_valid && m_ctl[4] && m_rd != 0 && if_valid &&
             ((d.u1 && if_instr[19:15] == m_rd) || (d.u2 && if_instr[24:20] == m_rd));
   endfunction

   function automatic logic model_ready();
      return !reset && !flush && (!m_valid || ex_ready) && !model_haz();
   endfunction

   // Advance the model by one clock edge using the current inputs.
   task automatic model_edge();
      dec_t d;
      logic adv, haz;
      if (reset) begin
         m_valid = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
         m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_flags = 0; m_f3 = 0; m_f7 = 0; m_ctl = 0;
         for (int i = 0; i < 32; i++) mrf[i] = 0;
         return;
      end
      adv = !m_valid || ex_ready;
      haz = model_haz();
      // Register contents as they stand after this edge; operands read from that view.
      if (wb_we && wb_rd != 0) mrf[wb_rd] = wb_data;
      if (flush) begin
         m_valid = 0; m_ctl = 0; m_flags = 0;
      end else if (adv && haz) begin
         m_valid = 0; m_ctl = 0;
      end else if (adv && if_valid) begin
         d = ref_decode(if_instr);
         m_valid = 1; m_pc = if_pc;
         m_rd = if_instr[11:7]; m_rs1 = if_instr[19:15]; m_rs2 = if_instr[24:20];
         m_f3 = if_instr[14:12]; m_f7 = if_instr[31:25];
         m_rs1d = mrf[m_rs1]; m_rs2d = mrf[m_rs2];
         m_ctl = d.ctl; m_imm = d.imm; m_flags = d.flags;
      end else if (adv) begin
         m_valid = 0; m_ctl = 0;
      end else begin
         m_rs1d = mrf[m_rs1]; m_rs2d = mrf[m_rs2];
      end
   endtask

   task automatic compare_all();
      check("id_valid",    32'(id_valid), 32'(m_valid));
      check("id_pc",       id_pc, m_pc);
      check("id_rs1_data", id_rs1_data, m_rs1d);
      check("id_rs2_data", id_rs2_data, m_rs2d);
      check("id_imm",      id_imm, m_imm);
      check("id_rd",       32'(id_rd), 32'(m_rd));
      check("id_rs1",      32'(id_rs1), 32'(m_rs1));
      check("id_rs2",      32'(id_rs2), 32'(m_rs2));
      check("id_funct3",   32'(id_funct3), 32'(m_f3));
      check("id_funct7",   32'(id_funct7), 32'(m_f7));
      check("id_ctl",      32'(id_ctl), 32'(m_ctl));
      check("id_flags",    32'({id_illegal, id_lui, id_auipc, id_jalr, id_jal}), 32'(m_flags));
   endtask

   // One clock: check if_ready before the edge, step the model, check outputs after.
   task automatic cycle();
      #2;
      rdy_seen = if_ready;
      check("if_ready", 32'(if_ready), 32'(model_ready()));
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
   endfunction

   logic [6:0] ops [10];

   initial begin
      for (int i = 0; i < 32; i++) mrf[i] = 0;
      reset = 1; if_valid = 0; wb_we = 0; flush = 0; ex_ready = 1;
      if_pc = 0; if_instr = 0; wb_data = 0; wb_rd = 0;

      // Reset for two cycles, then idle
      cycle(); cycle();
      reset = 0;
      cycle();
      check("post_reset_valid", 32'(id_valid), 32'd0);
      check("post_reset_ctl",   32'(id_ctl), 32'd0);

      // Every register reads zero after reset
      if_valid = 1;
      for (int i = 1; i < 32; i++) begin
         if_instr = r_type(5'd0, 5'(i), 5'(i));
         if_pc = 32'(i * 4);
         cycle();
         check("rf_zero", id_rs1_data, 32'd0);
      end

      // Writeback bypass into the instruction being accepted
      if_instr = r_type(5'd3, 5'd5, 5'd0);
      wb_we = 1; wb_rd = 5'd5; wb_data = 32'h1234;
      cycle();
      wb_we = 0;
      check("bypass_rs1", id_rs1_data, 32'h1234);
      check("bypass_ctl", 32'(id_ctl), 32'h22);
      check("bypass_valid", 32'(id_valid), 32'd1);

      // Load-use: lw x7,4(x1) then add x8,x7,x2
      if_instr = {12'd4, 5'd1, 3'b010, 5'd7, 7'h03};
      cycle();
      if_instr = r_type(5'd8, 5'd7, 5'd2);
      cycle();
      check("lu_ready", 32'(rdy_seen), 32'd0);
      check("lu_bubble", 32'(id_valid), 32'd0);
      cycle();
      check("lu_ready2", 32'(rdy_seen), 32'd1);
      check("lu_capture", 32'(id_rs1), 32'd7);
      check("lu_valid", 32'(id_valid), 32'd1);

      // Operand refresh while held: addi x9,x4,-1 then x4 <= 0xAA
      if_instr = {12'hFFF, 5'd4, 3'd0, 5'd9, 7'h13};
      cycle();
      ex_ready = 0;
      if_instr = r_type(5'd1, 5'd1, 5'd1);
      wb_we = 1; wb_rd = 5'd4; wb_data = 32'hAA;
      cycle();
      wb_we = 0;
      check("hold_ready", 32'(rdy_seen), 32'd0);
      check("hold_rs1d", id_rs1_data, 32'hAA);
      check("hold_imm", id_imm, 32'hFFFF_FFFF);
      check("hold_rd", 32'(id_rd), 32'd9);
      cycle();
      check("hold_ready2", 32'(rdy_seen), 32'd0);
      check("hold_rs1d2", id_rs1_data, 32'hAA);

      // LUI then flush with beq presented
      ex_ready = 1;
      if_instr = {20'hABCDE, 5'd2, 7'h37};
      cycle();
      check("lui_imm", id_imm, 32'hABCD_E000);
      check("lui_flag", 32'(id_lui), 32'd1);
      if_instr = {7'd0, 5'd2, 5'd1, 3'd0, 5'b01000, 7'h63};
      flush = 1;
      cycle();
      flush = 0;
      check("flush_ready", 32'(rdy_seen), 32'd0);
      check("flush_valid", 32'(id_valid), 32'd0);
      check("flush_ctl", 32'(id_ctl), 32'd0);
      check("flush_lui", 32'(id_lui), 32'd0);
      if_valid = 0;
      cycle();

      // RV32E: high register index and unknown opcode are illegal
      if_valid = 1;
      if_instr = r_type(5'd17, 5'd1, 5'd2);
      cycle();
      check("e_ill_idx", 32'(e_illegal), 32'd1);
      check("e_ill_ctl", 32'(e_ctl), 32'd0);
      check("e_ill_valid", 32'(e_valid), 32'd1);
      check("i_legal_idx", 32'(id_illegal), 32'd0);
      if_instr = 32'h0000_007F;
      cycle();
      check("e_ill_op", 32'(e_illegal), 32'd1);
      check("e_ill_imm", e_imm, 32'd0);
      check("i_ill_op", 32'(id_illegal), 32'd1);

      // Random traffic
      ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37};
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] w;
         logic [6:0]  op;
         w = $urandom;
         w[11:7]  = 5'($urandom_range(0, 7));
         w[19:15] = 5'($urandom_range(0, 7));
         w[24:20] = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) op = 7'($urandom);
         else op = ops[$urandom_range(0, 9)];
         w[6:0]   = op;
         if_instr = w;
         if_pc    = $urandom;
         if_valid = ($urandom_range(0, 3) != 0);
         ex_ready = ($urandom_range(0, 9) < 7);
         flush    = ($urandom_range(0, 15) == 0);
         wb_we    = ($urandom_range(0, 1) == 1);
         wb_rd    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         wb_data  = $urandom;
         reset    = ($urandom_range(0, 399) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
